// File: rtl/qrs_window_scheduler.sv
// QRS search-window / refractory sequencer: opens a bounded peak-search window on trigger,
// reports beats with RR interval, flags empty windows. Optional RR averaging under QRS_RR_AVG_EN.
module qrs_window_scheduler #(
  parameter int QRS_WIN_LEN = 36,
  parameter int REFRACT_LEN = 72,
  parameter int RR_WIDTH    = 12
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_ce,
  input  logic                i_enable,
  input  logic                i_qrs_trigger,
  input  logic                i_extremum_found,
  output logic                o_qrs_win_active,
  output logic                o_refractory_active,
  output logic                o_beat_valid,
  output logic [RR_WIDTH-1:0] o_rr_interval,
  output logic                o_first_beat,
  output logic                o_win_timeout,
`ifdef QRS_RR_AVG_EN
  output logic [RR_WIDTH-1:0] o_rr_avg,
`endif
  output logic [1:0]          o_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WIN  = 2'd1;
  localparam logic [1:0] S_REFR = 2'd2;

  localparam int WW = $clog2(QRS_WIN_LEN);
  localparam int RW = $clog2(REFRACT_LEN);
  localparam logic [WW-1:0]       WIN_LAST  = WW'(QRS_WIN_LEN - 1);
  localparam logic [RW-1:0]       REFR_LAST = RW'(REFRACT_LEN - 1);
  localparam logic [RR_WIDTH-1:0] RR_MAX    = '1;

  logic [1:0]          state;
  logic [WW-1:0]       win_cnt;
  logic [RW-1:0]       refr_cnt;
  logic [RR_WIDTH-1:0] rr_cnt;
  logic                first_flag;
  logic                beat;

  assign beat                = (state == S_WIN) && i_extremum_found;
  assign o_state             = state;
  assign o_qrs_win_active    = (state == S_WIN);
  assign o_refractory_active = (state == S_REFR);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= S_IDLE;
      win_cnt       <= '0;
      refr_cnt      <= '0;
      rr_cnt        <= '0;
      first_flag    <= 1'b1;
      o_beat_valid  <= 1'b0;
      o_win_timeout <= 1'b0;
      o_rr_interval <= '0;
      o_first_beat  <= 1'b0;
    end else begin
      o_beat_valid  <= 1'b0;
      o_win_timeout <= 1'b0;
      if (!i_enable) begin
        // o_rr_interval deliberately holds across a disable.
        state      <= S_IDLE;
        win_cnt    <= '0;
        refr_cnt   <= '0;
        rr_cnt     <= '0;
        first_flag <= 1'b1;
      end else begin
        if (beat)
          rr_cnt <= '0;
        else if (i_ce && rr_cnt != RR_MAX)
          rr_cnt <= rr_cnt + RR_WIDTH'(1);

        case (state)
          S_IDLE: begin
            if (i_qrs_trigger) begin
              state   <= S_WIN;
              win_cnt <= '0;
            end
          end
          S_WIN: begin
            // An extremum on the final strobe wins over the timeout.
            if (i_extremum_found) begin
              state         <= S_REFR;
              refr_cnt      <= '0;
              o_beat_valid  <= 1'b1;
              o_rr_interval <= rr_cnt;
              o_first_beat  <= first_flag;
              first_flag    <= 1'b0;
            end else if (i_ce) begin
              if (win_cnt == WIN_LAST) begin
                state         <= S_IDLE;
                o_win_timeout <= 1'b1;
              end else begin
                win_cnt <= win_cnt + WW'(1);
              end
            end
          end
          S_REFR: begin
            if (i_ce) begin
              if (refr_cnt == REFR_LAST)
                state <= S_IDLE;
              else
                refr_cnt <= refr_cnt + RW'(1);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef QRS_RR_AVG_EN
  localparam int AW = RR_WIDTH + 3;

  logic [RR_WIDTH-1:0] hist [8];
  logic [2:0]          hist_ptr;
  logic [AW-1:0]       acc;

  // Running sum of the last eight non-first RR values; the average lags the beat by one clock.
  // NOTE: the 8-entry history is reset explicitly because stale entries would corrupt the running sum.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 8; i++) hist[i] <= '0;
      hist_ptr <= '0;
      acc      <= '0;
      o_rr_avg <= '0;
    end else if (!i_enable) begin
      for (int i = 0; i < 8; i++) hist[i] <= '0;
      hist_ptr <= '0;
      acc      <= '0;
      o_rr_avg <= '0;
    end else begin
      o_rr_avg <= RR_WIDTH'(acc >> 3);
      if (beat && !first_flag) begin
        acc            <= acc + AW'(rr_cnt) - AW'(hist[hist_ptr]);
        hist[hist_ptr] <= rr_cnt;
        hist_ptr       <= hist_ptr + 3'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_qrs_window_scheduler.sv
// Self-checking bench for qrs_window_scheduler: countdown reference model feeds a beat scoreboard;
// per-cycle state/pulse comparison plus directed boundary checks.
module tb_qrs_window_scheduler;

  localparam int WIN  = 36;
  localparam int REFR = 72;
  localparam int RRW  = 12;

  logic           clk = 1'b0;
  logic           rst;
  logic           ce, enable, trig, ext;
  logic           win_active, refr_active, beat_valid, first_beat, win_timeout;
  logic [RRW-1:0] rr_interval;
  logic [1:0]     state;
`ifdef QRS_RR_AVG_EN
  logic [RRW-1:0] rr_avg;
`endif

  always #5 clk = ~clk;

  qrs_window_scheduler dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_ce                (ce),
    .i_enable            (enable),
    .i_qrs_trigger       (trig),
    .i_extremum_found    (ext),
    .o_qrs_win_active    (win_active),
    .o_refractory_active (refr_active),
    .o_beat_valid        (beat_valid),
    .o_rr_interval       (rr_interval),
    .o_first_beat        (first_beat),
    .o_win_timeout       (win_timeout),
`ifdef QRS_RR_AVG_EN
    .o_rr_avg            (rr_avg),
`endif
    .o_state             (state)
  );

  typedef struct packed {
    logic [RRW-1:0] rr;
    logic           first;
  } beat_t;

  beat_t sb[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    ce_since = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: windows and refractory counted down from their lengths.
  logic [1:0]     m_state;
  int             m_left;
  int             m_rr;
  logic           m_first, m_beat, m_to;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state <= 2'd0; m_left <= 0; m_rr <= 0; m_first <= 1'b1;
      m_beat <= 1'b0; m_to <= 1'b0;
      sb.delete();
    end else if (!enable) begin
      m_state <= 2'd0; m_rr <= 0; m_first <= 1'b1; m_beat <= 1'b0; m_to <= 1'b0;
    end else begin
      m_beat <= 1'b0;
      m_to   <= 1'b0;
      if (m_state == 2'd1 && ext) m_rr <= 0;
      else if (ce)                m_rr <= (m_rr >= (1 << RRW) - 1) ? m_rr : m_rr + 1;
      if (m_state == 2'd0) begin
        if (trig) begin m_state <= 2'd1; m_left <= WIN; end
      end else if (m_state == 2'd1) begin
        if (ext) begin
          sb.push_back('{rr: RRW'(m_rr), first: m_first});
          m_beat <= 1'b1; m_first <= 1'b0; m_state <= 2'd2; m_left <= REFR;
        end else if (ce) begin
          if (m_left == 1) begin m_state <= 2'd0; m_to <= 1'b1; end
          else m_left <= m_left - 1;
        end
      end else if (ce) begin
        if (m_left == 1) m_state <= 2'd0;
        else m_left <= m_left - 1;
      end
    end
  end

  // One clock: drive at negedge, let the edge pass, compare at the next negedge.
  task automatic step(input logic t, input logic x);
    beat_t e;
    trig = t;
    ext  = x;
    ce   = (cyc % 4 == 0);
    if (ce) ce_since++;
    cyc++;
    @(posedge clk);
    @(negedge clk);
    check("state", 32'(state), 32'(m_state));
    check("beat", 32'(beat_valid), 32'(m_beat));
    check("timeout", 32'(win_timeout), 32'(m_to));
    if (beat_valid) begin
      if (sb.size() == 0) check("sb_underflow", 1, 0);
      else begin
        e = sb.pop_front();
        check("beat_rr", 32'(rr_interval), 32'(e.rr));
        check("beat_first", 32'(first_beat), 32'(e.first));
      end
    end
  endtask

  task automatic run_until_ce(input int target);
    while (ce_since < target) step(1'b0, 1'b0);
  endtask

  task automatic wait_idle();
    for (int g = 0; g < 2000 && state != 2'd0; g++) step(1'b0, 1'b0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, nb;
    rst = 1'b1; enable = 1'b0; trig = 1'b0; ext = 1'b0; ce = 1'b0;
    #2;
    check("rst_state", 32'(state), 0);
    check("rst_rr", 32'(rr_interval), 0);
    check("rst_pulses", 32'({beat_valid, win_timeout, win_active, refr_active, first_beat}), 0);
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b1;
    step(1'b0, 1'b0);

    // First beat, extremum 10 strobes into the window.
    step(1'b1, 1'b0);
    ce_since = 0;
    run_until_ce(10);
    step(1'b0, 1'b1);
    check("first_beat", 32'(first_beat), 1);
    ce_since = 0;
    t0 = ce_since;
    for (int g = 0; g < 2000 && state == 2'd2; g++) step(1'b0, 1'b0);
    check("refr_len", 32'(ce_since - t0), REFR);

    // Second beat 300 strobes after the first.
    run_until_ce(290);
    step(1'b1, 1'b0);
    run_until_ce(300);
    step(1'b0, 1'b1);
    check("rr_300", 32'(rr_interval), 300);
    check("rr_300_first", 32'(first_beat), 0);
    wait_idle();

    // Empty window times out on its 36th strobe.
    step(1'b1, 1'b0);
    t0 = ce_since;
    for (int g = 0; g < 2000 && state == 2'd1; g++) step(1'b0, 1'b0);
    check("win_len", 32'(ce_since - t0), WIN);
    check("timeout_pulse", 32'(win_timeout), 1);
    check("rr_held", 32'(rr_interval), 300);

    // Extremum coinciding with the final strobe: beat, no timeout.
    step(1'b1, 1'b0);
    t0 = ce_since;
    run_until_ce(t0 + WIN - 1);
    while (cyc % 4 != 0) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("last_ce_beat", 32'(beat_valid), 1);
    check("last_ce_no_to", 32'(win_timeout), 0);
    check("last_ce_refr", 32'(state), 2);

    // Triggers and extremum hammered through REFR, including its exit cycle.
    nb = 0;
    for (int g = 0; g < 2000 && state == 2'd2; g++) begin
      step(1'b1, 1'b1);
      nb += int'(beat_valid);
    end
    check("refr_no_beats", 32'(nb), 0);
    check("refr_exit_idle", 32'(state), 0);

    // Saturation after 5000 quiet strobes.
    t0 = ce_since;
    run_until_ce(t0 + 5000);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    check("rr_sat", 32'(rr_interval), 4095);
    wait_idle();

    // Enable dropped mid-window.
    step(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
    enable = 1'b0;
    step(1'b0, 1'b1);
    check("dis_idle", 32'(state), 0);
    check("dis_no_pulse", 32'({beat_valid, win_timeout}), 0);
    check("dis_rr_hold", 32'(rr_interval), 4095);
    enable = 1'b1;
    step(1'b1, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("reen_first", 32'(first_beat), 1);

    // Async reset mid-refractory, between clock edges.
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0);
    check("pre_rst_refr", 32'(state), 2);
    #1 rst = 1'b1;
    #1;
    check("arst_state", 32'(state), 0);
    check("arst_outs", 32'({win_active, refr_active, beat_valid, win_timeout, first_beat}), 0);
    check("arst_rr", 32'(rr_interval), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);

`ifdef QRS_RR_AVG_EN
    // Nine beats: the first is not averaged, the next eight all at RR=200.
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    ce_since = 0;
    for (int b = 0; b < 8; b++) begin
      run_until_ce(180);
      step(1'b1, 1'b0);
      run_until_ce(200);
      step(1'b0, 1'b1);
      check("avg_rr", 32'(rr_interval), 200);
      ce_since = 0;
    end
    step(1'b0, 1'b0);
    check("rr_avg", 32'(rr_avg), 200);
`endif

    check("sb_empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
